gauss_blur_3x3: RTL and testbench
=================================

Name: gauss_blur_3x3

Overview:
- Streaming 3x3 Gaussian smoothing stage placed directly downstream of the RGB-to-grayscale converter.
- Consumes the 8-bit grayscale pixel stream and its per-pixel valid strobe.
- Buffers two image lines and emits blurred interior pixels in raster order.
- Output feeds the feature-detection / stitching front end.

Parameters:
- IMG_W, 640, pixels per line (>= 3)
- IMG_H, 480, lines per frame (>= 3)
- DW, 8, pixel width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- pix_i  in  DW  grayscale pixel
- valid_i  in  1  pix_i valid this cycle; no backpressure, gaps allowed
- sof_i  in  1  qualified by valid_i; marks pixel (0,0) of a frame
- blur_o  out  DW  smoothed pixel
- valid_o  out  1  blur_o valid, one cycle per output pixel
- frame_done_o  out  1  one-cycle pulse coincident with the last output pixel of a frame

Behaviour:
- Reset (rst=0, asynchronous): blur_o=0, valid_o=0, frame_done_o=0, col/row counters=0, 3x3 window registers=0. Line RAMs are not reset.
- Counters: col advances only on valid_i. It wraps IMG_W-1 -> 0 and increments row. row wraps IMG_H-1 -> 0.
- sof_i with valid_i: the pixel is treated as (0,0) regardless of counter state. Counters continue from (0,1).
- Line buffers: lb0 holds row r-1 and lb1 holds row r-2, each depth IMG_W, indexed by col.
  - Read is combinational. Read-during-write returns old data.
  - On an accepted pixel at col c: the window shifts left and new column {lb1[c], lb0[c], pix_i} enters on the right. Then lb1[c] <= lb0[c] and lb0[c] <= pix_i.
- Output condition: an accepted pixel at (r,c) with r>=2 and c>=2 completes the window centred on (r-1,c-1). Only interior pixels are emitted: (IMG_W-2)*(IMG_H-2) outputs per frame.
- Arithmetic:
  - Kernel weights are [1 2 1; 2 4 2; 1 2 1].
  - The sum is DW+4 bits wide (max 4080 for DW=8).
  - blur_o = (sum + 8) >> 4. No saturation is needed, since the maximum result is 255.
- Pipeline: a pixel is accepted at edge N. The window updates at edge N. blur_o and valid_o are registered at edge N+1 and are high for the cycle after edge N+1.
  - Two accepted pixels in consecutive cycles give two consecutive valid_o cycles.
  - When no qualifying pixel was accepted, valid_o=0 and blur_o holds its last value.
- frame_done_o: asserted with the valid_o of the output triggered by input (IMG_H-1, IMG_W-1).
- Mid-frame reset: outputs drop to 0 immediately. The next accepted pixel is (0,0). Stale RAM contents are never emitted, because rows 0 and 1 are rewritten before r>=2.
- Mid-frame sof_i: the partial frame is abandoned. No frame_done_o is issued for it.

Optional Feature:
- Macro: GAUSS_BLUR_ERR_FLAG_EN.
- With the macro: adds output port err_o (1 bit, reset 0).
  - err_o is set sticky when sof_i arrives with valid_i while counters != (0,0).
  - err_o is also set when a pixel is accepted at (0,0) without sof_i.
  - err_o is cleared only by reset.
- Without the macro: port and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package gauss_pkg holds:
  - kernel weight constants
  - normalisation shift (4) and rounding constant (8)
  - sum width function DW+4
- Sub-module line_ram:
  - depth IMG_W x DW
  - one write port, combinational read, read-old-on-collision
  - instantiated twice (lb0, lb1)
- Window registers, counters and the adder tree stay in gauss_blur_3x3.

Test Plan:
- IMG_W=8, IMG_H=6, all pixels 100, continuous valid_i -> 24 outputs all 100. frame_done_o on the 24th. valid_o lags each qualifying input by 2 edges.
- Impulse 160 at (2,3), all else 0 ->
  - output at (2,3) = 40
  - (1,3), (3,3), (2,2), (2,4) = 20
  - (1,2), (1,4), (3,2), (3,4) = 10
  - all other outputs 0
- Rounding: all 255 -> all 255. Impulse of value 1 -> centre output 0. Impulse 2 -> centre 1.
- Random valid_i gaps (about 40% idle) on the impulse frame -> output sequence identical to the gapless run. valid_o never high without a qualifying accept 2 edges earlier.
- rst=0 mid-row 3 -> blur_o, valid_o and frame_done_o go 0 without waiting for clk. The following frame reproduces the first scenario's outputs exactly.
- sof_i at (4,5) mid-frame -> no frame_done_o for the aborted frame, the new frame outputs are correct, and (with GAUSS_BLUR_ERR_FLAG_EN) err_o=1 sticky until reset.

Source files
------------

// File: rtl/gauss_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : gauss_pkg
//  Description : Shared constants for the 3x3 Gaussian blur stage.
//                Holds the kernel weights [1 2 1; 2 4 2; 1 2 1], the
//                normalisation shift and rounding constant, and a helper
//                that sizes the weighted-sum accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package gauss_pkg;

    // Kernel weights by tap position.
    localparam int c_k_corner = 1;
    localparam int c_k_edge   = 2;
    localparam int c_k_center = 4;

    // The weights sum to 16: divide by 16 with round-half-up.
    localparam int c_norm_shift = 4;
    localparam int c_round      = 8;

    // The weighted sum of nine DW-bit pixels (total weight 16) needs 4 extra bits.
    function automatic int sum_width(input int dw);
        return dw + 4;
    endfunction

endpackage : gauss_pkg
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : line_ram
//  Description : Single-line pixel store, DEPTH x DW, one write port and an
//                asynchronous read port. A read at the address being written
//                in the same cycle returns the previous contents.
//                The storage array has no reset.
//  Ports       : clk   - clock, rising edge
//                we    - write enable
//                addr  - shared read/write address (pixel column)
//                wdata - write data
//                rdata - combinational read data
//  Revision    : 1.0 - initial release
// ============================================================================
module line_ram
    import gauss_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // The non-blocking write lands after the combinational read,
    // so a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule : line_ram
`default_nettype wire

// File: rtl/gauss_blur_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : gauss_blur_3x3
//  Description : Streaming 3x3 Gaussian smoothing of an 8-bit grayscale
//                raster. Two line RAMs feed a 3x3 window. Each accepted pixel
//                at (r,c), r>=2 and c>=2, completes the window centred on
//                (r-1,c-1). That window's rounded, normalised sum appears on
//                blur_o one cycle later.
//  Ports       : clk          - clock, rising edge
//                rst          - asynchronous reset, active low
//                pix_i        - grayscale pixel
//                valid_i      - pix_i valid (no backpressure)
//                sof_i        - start of frame, qualified by valid_i
//                blur_o       - smoothed pixel
//                valid_o      - blur_o valid
//                frame_done_o - pulse with the last output pixel of a frame
//                err_o        - sticky framing error (GAUSS_BLUR_ERR_FLAG_EN)
//  Options     : `define GAUSS_BLUR_ERR_FLAG_EN adds the err_o port
//  Revision    : 1.0 - initial release
// ============================================================================
module gauss_blur_3x3
    import gauss_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pix_i,
    input  logic          valid_i,
    input  logic          sof_i,
    output logic [DW-1:0] blur_o,
    output logic          valid_o,
    output logic          frame_done_o
`ifdef GAUSS_BLUR_ERR_FLAG_EN
    ,
    output logic          err_o
`endif
);

    localparam int c_cw = $clog2(IMG_W);
    localparam int c_rw = $clog2(IMG_H);
    localparam int c_sw = sum_width(DW);

    localparam logic [c_cw-1:0] c_col_last = c_cw'(IMG_W - 1);
    localparam logic [c_rw-1:0] c_row_last = c_rw'(IMG_H - 1);
    localparam logic [c_cw-1:0] c_col_two  = c_cw'(2);
    localparam logic [c_rw-1:0] c_row_two  = c_rw'(2);

    logic [c_cw-1:0] r_col;
    logic [c_rw-1:0] r_row;
    logic [c_cw-1:0] w_col;
    logic [c_rw-1:0] w_row;
    logic [c_cw-1:0] w_col_nxt;
    logic [c_rw-1:0] w_row_nxt;
    logic            w_col_end;
    logic            w_qual;
    logic            w_last;
    logic [DW-1:0]   w_lb0_q;
    logic [DW-1:0]   w_lb1_q;
    // r_win[row][col]: row 0 is the oldest line, col 2 the newest column.
    logic [DW-1:0]   r_win [3][3];
    logic            r_win_ok;
    logic            r_win_last;
    logic [c_sw-1:0] w_sum;
    logic [DW-1:0]   w_blur;

    // Raster position of the pixel on pix_i. sof_i forces it to (0,0).
    assign w_col     = sof_i ? '0 : r_col;
    assign w_row     = sof_i ? '0 : r_row;
    assign w_col_end = (w_col == c_col_last);
    assign w_col_nxt = w_col_end ? '0 : w_col + 1'b1;
    assign w_row_nxt = !w_col_end ? w_row :
                       (w_row == c_row_last) ? '0 : w_row + 1'b1;
    assign w_qual    = (w_row >= c_row_two) && (w_col >= c_col_two);
    assign w_last    = (w_row == c_row_last) && w_col_end;

    // lb0 holds line r-1, lb1 holds line r-2. lb1 is refilled from the
    // old lb0 word, so together they form a two-line shift register.
    line_ram #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
        .clk   (clk),
        .we    (valid_i),
        .addr  (w_col),
        .wdata (pix_i),
        .rdata (w_lb0_q)
    );

    line_ram #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
        .clk   (clk),
        .we    (valid_i),
        .addr  (w_col),
        .wdata (w_lb0_q),
        .rdata (w_lb1_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (valid_i) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (valid_i) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_lb1_q;
            r_win[1][2] <= w_lb0_q;
            r_win[2][2] <= pix_i;
        end
    end

    assign w_sum =
          c_sw'(c_k_corner) * (c_sw'(r_win[0][0]) + c_sw'(r_win[0][2])
                             + c_sw'(r_win[2][0]) + c_sw'(r_win[2][2]))
        + c_sw'(c_k_edge)   * (c_sw'(r_win[0][1]) + c_sw'(r_win[1][0])
                             + c_sw'(r_win[1][2]) + c_sw'(r_win[2][1]))
        + c_sw'(c_k_center) * c_sw'(r_win[1][1]);

    // The maximum sum plus rounding still fits in c_sw bits, and after the
    // shift the result is at most 255, so no saturation is needed.
    assign w_blur = DW'((w_sum + c_sw'(c_round)) >> c_norm_shift);

    // Stage 1 records whether the window just loaded is an output window.
    // Stage 2 registers the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_ok     <= 1'b0;
            r_win_last   <= 1'b0;
            blur_o       <= '0;
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            r_win_ok     <= valid_i && w_qual;
            r_win_last   <= valid_i && w_last;
            valid_o      <= r_win_ok;
            frame_done_o <= r_win_last;
            if (r_win_ok) begin
                blur_o <= w_blur;
            end
        end
    end

`ifdef GAUSS_BLUR_ERR_FLAG_EN
    logic w_at_origin;
    assign w_at_origin = (r_row == '0) && (r_col == '0);

    // Error: sof_i away from (0,0), or a pixel at (0,0) without sof_i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_o <= 1'b0;
        end else if (valid_i && (sof_i != w_at_origin)) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule : gauss_blur_3x3
`default_nettype wire

// File: tb/tb_gauss_blur_3x3.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_gauss_blur_3x3
//  Description : Self-checking bench for gauss_blur_3x3 on an 8x6 image.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gauss_blur_3x3;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] pix_i = '0;
    logic          valid_i = 1'b0;
    logic          sof_i = 1'b0;
    logic [DW-1:0] blur_o;
    logic          valid_o;
    logic          frame_done_o;
`ifdef GAUSS_BLUR_ERR_FLAG_EN
    logic          err_o;
`endif

    gauss_blur_3x3 #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_i        (pix_i),
        .valid_i      (valid_i),
        .sof_i        (sof_i),
        .blur_o       (blur_o),
        .valid_o      (valid_o),
        .frame_done_o (frame_done_o)
`ifdef GAUSS_BLUR_ERR_FLAG_EN
        ,
        .err_o        (err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        int val;
        bit done;
    } exp_t;

    typedef struct {
        int bg;
        int imp;
        int ir;
        int ic;
        int pr;
        int pc;
        int want;
        int gap;
    } vec_t;

    exp_t exp_q[$];
    int   img [H][W];
    int   got [H][W];
    int   total = 0;
    int   bad = 0;
    int   out_cnt = 0;
    bit   tb_qual = 1'b0;
    bit   q_d1 = 1'b0;
    bit   q_d2 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference model: every interior centre (r,c) whose bottom-right
    // neighbour (r+1,c+1) is among the first npix pixels of the frame.
    task automatic push_model(input int npix);
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                int trig;
                int sum;
                trig = (r + 1) * W + (c + 1);
                if (trig < npix) begin
                    sum = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            sum += (2 - iabs(dr)) * (2 - iabs(dc)) * img[r + dr][c + dc];
                    exp_q.push_back('{r, c, (sum + 8) / 16, trig == W * H - 1});
                end
            end
        end
    endtask

    task automatic drive_frame(input int npix, input int gap, input bit use_sof);
        push_model(npix);
        for (int t = 0; t < npix; t++) begin
            while ($urandom_range(99) < gap) begin
                @(negedge clk);
                valid_i = 1'b0;
                sof_i   = 1'b0;
                tb_qual = 1'b0;
            end
            @(negedge clk);
            valid_i = 1'b1;
            pix_i   = 8'(img[t / W][t % W]);
            sof_i   = use_sof && (t == 0);
            tb_qual = (t / W >= 2) && (t % W >= 2);
        end
        @(negedge clk);
        valid_i = 1'b0;
        sof_i   = 1'b0;
        tb_qual = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: %0d outputs still outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        q_d1 = 1'b0;
        q_d2 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fill(input int bg, input int imp, input int ir, input int ic);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = bg;
        if (imp >= 0) img[ir][ic] = imp;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = int'($urandom_range(255));
    endtask

    task automatic clear_got();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                got[r][c] = -1;
    endtask

    // Record, at each edge, whether the bench presented a qualifying pixel.
    always @(posedge clk) begin
        if (!rst) begin
            q_d1 = 1'b0;
            q_d2 = 1'b0;
        end else begin
            q_d2 = q_d1;
            q_d1 = valid_i && tb_qual;
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            check("valid_latency", valid_o, q_d2);
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_output: got value %0d, expected no output", blur_o);
                end else begin
                    e = exp_q.pop_front();
                    got[e.r][e.c] = int'(blur_o);
                    out_cnt++;
                    check($sformatf("pix(%0d,%0d)", e.r, e.c), blur_o, e.val);
                    check($sformatf("frame_done(%0d,%0d)", e.r, e.c), frame_done_o, e.done);
                end
            end else begin
                check("frame_done_idle", frame_done_o, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        tbl[0]  = '{0,   160, 2, 3, 2, 3, 40,  0};
        tbl[1]  = '{0,   160, 2, 3, 1, 3, 20,  40};
        tbl[2]  = '{0,   160, 2, 3, 3, 3, 20,  0};
        tbl[3]  = '{0,   160, 2, 3, 2, 2, 20,  40};
        tbl[4]  = '{0,   160, 2, 3, 2, 4, 20,  0};
        tbl[5]  = '{0,   160, 2, 3, 1, 2, 10,  40};
        tbl[6]  = '{0,   160, 2, 3, 1, 4, 10,  0};
        tbl[7]  = '{0,   160, 2, 3, 3, 2, 10,  40};
        tbl[8]  = '{0,   160, 2, 3, 3, 4, 10,  0};
        tbl[9]  = '{0,   160, 2, 3, 4, 3, 0,   40};
        tbl[10] = '{0,   160, 2, 3, 2, 6, 0,   0};
        tbl[11] = '{255, -1,  0, 0, 4, 6, 255, 40};
        tbl[12] = '{0,   1,   2, 3, 2, 3, 0,   0};
        tbl[13] = '{0,   2,   2, 3, 2, 3, 1,   40};
        tbl[14] = '{0,   160, 0, 0, 1, 1, 10,  0};
        tbl[15] = '{100, -1,  0, 0, 1, 1, 100, 40};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_blur", blur_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_frame_done", frame_done_o, 0);
`ifdef GAUSS_BLUR_ERR_FLAG_EN
        check("rst_err", err_o, 0);
`endif
        rst = 1'b1;

        // Flat 100 frame, continuous valid.
        fill(100, -1, 0, 0);
        clear_got();
        out_cnt = 0;
        drive_frame(W * H, 0, 1'b1);
        wait_drain("flat_drain");
        check("flat_count", out_cnt, (W - 2) * (H - 2));
        check("flat_last", got[H - 2][W - 2], 100);
`ifdef GAUSS_BLUR_ERR_FLAG_EN
        check("err_clean_frame", err_o, 0);
`endif

        // Impulse, rounding and boundary vectors.
        for (int i = 0; i < 16; i++) begin
            fill(tbl[i].bg, tbl[i].imp, tbl[i].ir, tbl[i].ic);
            clear_got();
            drive_frame(W * H, tbl[i].gap, 1'b1);
            wait_drain($sformatf("vec%0d_drain", i));
            check($sformatf("vec%0d(%0d,%0d)", i, tbl[i].pr, tbl[i].pc),
                  got[tbl[i].pr][tbl[i].pc], tbl[i].want);
        end

        // Random images with and without idle gaps.
        for (int k = 0; k < 6; k++) begin
            fill_rand();
            drive_frame(W * H, (k % 2 == 0) ? 40 : 0, 1'b1);
            wait_drain($sformatf("rand%0d_drain", k));
        end

        // Asynchronous reset partway through row 3.
        fill(100, -1, 0, 0);
        drive_frame(3 * W + 4, 0, 1'b1);
        @(posedge clk);
        #2;
        check("pre_rst_valid", valid_o, 1);
        rst = 1'b0;
        exp_q.delete();
        q_d1 = 1'b0;
        q_d2 = 1'b0;
        #1;
        check("async_rst_blur", blur_o, 0);
        check("async_rst_valid", valid_o, 0);
        check("async_rst_done", frame_done_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_got();
        out_cnt = 0;
        drive_frame(W * H, 0, 1'b0);
        wait_drain("post_rst_drain");
        check("post_rst_count", out_cnt, (W - 2) * (H - 2));
        check("post_rst_first", got[1][1], 100);

        // sof_i at (4,5) aborts the frame in progress.
        do_reset();
`ifdef GAUSS_BLUR_ERR_FLAG_EN
        check("err_after_reset", err_o, 0);
`endif
        out_cnt = 0;
        fill_rand();
        drive_frame(4 * W + 5, 0, 1'b1);
        fill_rand();
        drive_frame(W * H, 0, 1'b1);
        wait_drain("abort_drain");
        check("abort_count", out_cnt, 15 + (W - 2) * (H - 2));
`ifdef GAUSS_BLUR_ERR_FLAG_EN
        check("err_set", err_o, 1);
        fill_rand();
        drive_frame(W * H, 40, 1'b1);
        wait_drain("sticky_drain");
        check("err_sticky", err_o, 1);
        do_reset();
        check("err_cleared", err_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gauss_blur_3x3
`default_nettype wire
